// File: rtl/packet_sink_rx_if.sv
// packet_sink_rx_if: word-side packet bus, byte-side stream and status of packet_sink_rx
//   in_valid/in_data/in_byte_enable/in_sop/in_eop : 64-bit word input, no backpressure
//   out_valid/out_data/out_sop/out_eop/out_ready  : byte stream with valid/ready handshake
//   stat_valid/stat_len/stat_err                  : per-packet status pulse
//   overflow                                      : sticky word-drop flag
//   master drives words and out_ready; slave is the receiver
interface packet_sink_rx_if;
    logic        in_valid;
    logic [63:0] in_data;
    logic [7:0]  in_byte_enable;
    logic        in_sop;
    logic        in_eop;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sop;
    logic        out_eop;
    logic        out_ready;
    logic        stat_valid;
    logic [15:0] stat_len;
    logic        stat_err;
    logic        overflow;

    modport master (
        output in_valid, in_data, in_byte_enable, in_sop, in_eop, out_ready,
        input  out_valid, out_data, out_sop, out_eop, stat_valid, stat_len, stat_err, overflow
    );

    modport slave (
        input  in_valid, in_data, in_byte_enable, in_sop, in_eop, out_ready,
        output out_valid, out_data, out_sop, out_eop, stat_valid, stat_len, stat_err, overflow
    );
endinterface

// File: rtl/packet_sink_rx.sv
// packet_sink_rx: checks packet framing, buffers words in a FIFO and serialises them to bytes
//   clk : sole clock, rising edge
//   rst : asynchronous active-high reset
//   bus : packet_sink_rx_if.slave (word input, byte output, status, overflow)
module packet_sink_rx #(
    parameter int FIFO_DEPTH = 8
) (
    input logic             clk,
    input logic             rst,
    packet_sink_rx_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_P = FIFO_DEPTH[AW:0];
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] IN_PKT = 1'b1;

    logic [0:0]  state;
    logic [63:0] mem_data [FIFO_DEPTH];
    logic [3:0]  mem_cnt  [FIFO_DEPTH];
    logic        mem_sop  [FIFO_DEPTH];
    logic        mem_eop  [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [2:0]  idx;
    logic [15:0] acc_len, base_len, next_len;
    logic        acc_err, base_err;
    logic [16:0] sum;
    logic [7:0]  inv_be;
    logic [3:0]  word_cnt, head_cnt;
    logic [63:0] head_shift;
    logic        full, empty, framed, push, mask_ok, word_err, last_byte, accept;

    always_comb begin
        empty      = wr_ptr == rd_ptr;
        full       = (wr_ptr - rd_ptr) == DEPTH_P;
        inv_be     = ~bus.in_byte_enable;
        // legal masks are MSB-aligned runs of ones: the complement is 2^k-1
        mask_ok    = bus.in_byte_enable != 8'd0 && (inv_be & (inv_be + 8'd1)) == 8'd0;
        word_cnt   = bus.in_eop && mask_ok ? 4'($countones(bus.in_byte_enable)) : 4'd8;
        framed     = bus.in_sop || state == IN_PKT;
        push       = bus.in_valid && framed && !full;
        word_err   = (bus.in_eop && !mask_ok) || full;
        // an sop word always begins a fresh count, even when it aborts an open packet
        base_len   = state == IN_PKT && !bus.in_sop ? acc_len : 16'd0;
        base_err   = state == IN_PKT && !bus.in_sop ? acc_err : 1'b0;
        sum        = {1'b0, base_len} + 17'(word_cnt);
        next_len   = sum[16] ? 16'hFFFF : sum[15:0];
        head_cnt   = mem_cnt[rd_ptr[AW-1:0]];
        last_byte  = {1'b0, idx} == head_cnt - 4'd1;
        accept     = !empty && bus.out_ready;
        head_shift = mem_data[rd_ptr[AW-1:0]] << {idx, 3'b000};
    end

    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? 8'd0 : head_shift[63:56];
    assign bus.out_sop   = !empty && mem_sop[rd_ptr[AW-1:0]] && idx == 3'd0;
    assign bus.out_eop   = !empty && mem_eop[rd_ptr[AW-1:0]] && last_byte;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr[AW-1:0]] <= bus.in_data;
            mem_cnt[wr_ptr[AW-1:0]]  <= word_cnt;
            mem_sop[wr_ptr[AW-1:0]]  <= bus.in_sop;
            mem_eop[wr_ptr[AW-1:0]]  <= bus.in_eop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            idx            <= 3'd0;
            acc_len        <= 16'd0;
            acc_err        <= 1'b0;
            bus.stat_valid <= 1'b0;
            bus.stat_len   <= 16'd0;
            bus.stat_err   <= 1'b0;
            bus.overflow   <= 1'b0;
        end else begin
            bus.stat_valid <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (bus.in_valid && framed && full)
                bus.overflow <= 1'b1;
            if (accept) begin
                idx <= last_byte ? 3'd0 : idx + 3'd1;
                if (last_byte)
                    rd_ptr <= rd_ptr + 1'b1;
            end
            if (bus.in_valid) begin
                if (!framed) begin
                    bus.stat_valid <= 1'b1;
                    bus.stat_len   <= 16'd0;
                    bus.stat_err   <= 1'b1;
                end else if (state == IN_PKT && bus.in_sop) begin
                    bus.stat_valid <= 1'b1;
                    bus.stat_len   <= acc_len;
                    bus.stat_err   <= 1'b1;
                    acc_len        <= next_len;
                    acc_err        <= word_err;
                    state          <= bus.in_eop ? IDLE : IN_PKT;
                end else if (bus.in_eop) begin
                    bus.stat_valid <= 1'b1;
                    bus.stat_len   <= next_len;
                    bus.stat_err   <= base_err || word_err;
                    state          <= IDLE;
                end else begin
                    acc_len <= next_len;
                    acc_err <= base_err || word_err;
                    state   <= IN_PKT;
                end
            end
        end
    end
endmodule

// File: tb/tb_packet_sink_rx.sv
// tb_packet_sink_rx: scoreboard bench for packet_sink_rx with directed and random traffic
module tb_packet_sink_rx;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    packet_sink_rx_if bus();
    packet_sink_rx #(.FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;
    logic [9:0]  exp_q [$];
    logic [16:0] stat_q [$];
    int          wq [$];
    bit in_pkt = 0;
    bit exp_ovf = 0;
    bit pkt_err = 0;
    int acc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat16(input int a);
        return a > 65535 ? 65535 : a;
    endfunction

    task automatic model(input logic [63:0] d, input logic [7:0] be, input bit s, input bit e);
        int n;
        bit legal;
        bit full;
        logic [7:0] m;
        legal = 0;
        n = 8;
        if (e)
            for (int k = 0; k < 8; k++) begin
                m = 8'hFF << k;
                if (be == m) begin
                    legal = 1;
                    n = 8 - k;
                end
            end
        if (!in_pkt && !s) begin
            stat_q.push_back({16'd0, 1'b1});
            return;
        end
        full = wq.size() >= DEPTH;
        if (full)
            exp_ovf = 1;
        else begin
            wq.push_back(n);
            for (int i = 0; i < n; i++)
                exp_q.push_back({d[63-8*i -: 8], s && i == 0, e && i == n - 1});
        end
        if (in_pkt && s) begin
            stat_q.push_back({16'(sat16(acc)), 1'b1});
            acc = 0;
            pkt_err = 0;
        end
        acc += n;
        pkt_err |= (e && !legal) || full;
        if (e) begin
            stat_q.push_back({16'(sat16(acc)), pkt_err});
            in_pkt = 0;
            acc = 0;
            pkt_err = 0;
        end else
            in_pkt = 1;
    endtask

    task automatic drive(input bit v, input logic [63:0] d, input logic [7:0] be,
                         input bit s, input bit e, input bit r);
        @(posedge clk);
        #1;
        bus.in_valid       = v;
        bus.in_data        = d;
        bus.in_byte_enable = be;
        bus.in_sop         = s;
        bus.in_eop         = e;
        bus.out_ready      = r;
        if (v)
            model(d, be, s, e);
    endtask

    task automatic drain();
        for (int i = 0; i < 600 && (exp_q.size() != 0 || stat_q.size() != 0); i++)
            drive(0, 64'd0, 8'd0, 0, 0, 1);
        drive(0, 64'd0, 8'd0, 0, 0, 1);
        chk("drain_bytes_left", 64'(exp_q.size()), 64'd0);
        chk("drain_stats_left", 64'(stat_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL byte_extra: got %0h with none expected", bus.out_data);
                end else begin
                    chk("byte", {54'd0, bus.out_data, bus.out_sop, bus.out_eop}, 64'(exp_q.pop_front()));
                    if (wq.size() != 0) begin
                        wq[0] = wq[0] - 1;
                        if (wq[0] == 0)
                            void'(wq.pop_front());
                    end
                end
            end
            if (bus.stat_valid) begin
                if (stat_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL stat_extra: got len %0d err %0d with none expected", bus.stat_len, bus.stat_err);
                end else
                    chk("stat", {47'd0, bus.stat_len, bus.stat_err}, 64'(stat_q.pop_front()));
            end
        end
    end

    initial begin
        bit v, s, e, r;
        int rmode;
        logic [7:0] be;
        logic [63:0] d;
        bus.in_valid = 0;
        bus.in_data = 0;
        bus.in_byte_enable = 0;
        bus.in_sop = 0;
        bus.in_eop = 0;
        bus.out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        chk("rst_out_data", 64'(bus.out_data), 0);
        chk("rst_out_sop", 64'(bus.out_sop), 0);
        chk("rst_out_eop", 64'(bus.out_eop), 0);
        chk("rst_stat_valid", 64'(bus.stat_valid), 0);
        chk("rst_stat_len", 64'(bus.stat_len), 0);
        chk("rst_stat_err", 64'(bus.stat_err), 0);
        chk("rst_overflow", 64'(bus.overflow), 0);
        rst = 0;

        drive(1, 64'h0001020304050607, 8'hFF, 1, 0, 1);
        drive(1, 64'h0809AAAABBBBCCCC, 8'hC0, 0, 1, 1);
        drain();

        drive(1, 64'h1122334455667788, 8'hFF, 1, 1, 1);
        drain();

        drive(1, 64'hDEADBEEFDEADBEEF, 8'hFF, 0, 0, 1);
        drain();

        drive(1, 64'hA0A1A2A3A4A5A6A7, 8'hFF, 1, 0, 1);
        drive(1, 64'hB0B1B2B3B4B5B6B7, 8'hFF, 0, 0, 1);
        drive(1, 64'hC0C1C2C3C4C5C6C7, 8'hFF, 1, 0, 1);
        drive(1, 64'hD0D1D2D3D4D5D6D7, 8'hFF, 0, 1, 1);
        drain();

        for (int i = 0; i <= DEPTH; i++)
            drive(1, {8{8'(i)}}, 8'hFF, i == 0, i == DEPTH, 0);
        drive(0, 64'd0, 8'd0, 0, 0, 0);
        chk("overflow_set", 64'(bus.overflow), 1);
        drain();

        drive(1, 64'h0123456789ABCDEF, 8'hFF, 1, 0, 1);
        drive(1, 64'hFEDCBA9876543210, 8'hA0, 0, 1, 1);
        drain();

        drive(1, 64'h5152535455565758, 8'hFF, 1, 1, 0);
        repeat (3) drive(0, 64'd0, 8'd0, 0, 0, 0);
        chk("pre_rst_out_valid", 64'(bus.out_valid), 1);
        rst = 1;
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 0);
        chk("mid_rst_overflow", 64'(bus.overflow), 0);
        exp_q.delete();
        wq.delete();
        exp_ovf = 0;
        in_pkt = 0;
        acc = 0;
        pkt_err = 0;
        @(posedge clk);
        #1;
        rst = 0;

        rmode = 1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0)
                rmode = $urandom_range(0, 3);
            r = rmode == 0 ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
            v = $urandom_range(0, 9) < 7;
            if (!in_pkt) begin
                s = $urandom_range(0, 9) != 0;
                e = s && $urandom_range(0, 3) == 0;
            end else begin
                s = $urandom_range(0, 19) == 0;
                e = !s && $urandom_range(0, 3) == 0;
            end
            if ($urandom_range(0, 4) == 0)
                be = 8'($urandom);
            else
                be = 8'hFF << $urandom_range(0, 7);
            d = {$urandom, $urandom};
            drive(v, d, be, s, e, r);
        end
        drain();
        chk("final_overflow", 64'(bus.overflow), 64'(exp_ovf));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/packet_sink_rx.md
# packet_sink_rx

Receive-side endpoint of the 64-bit packet interface (valid/data/byte_enable/sop/eop). Checks framing, buffers words in a small FIFO and serialises them into a byte stream with valid/ready backpressure. Reports per-packet byte length and error status. Sits between the packet interface and the byte-oriented dissector logic.

## Interface

Parameters:
- FIFO_DEPTH, 8, word FIFO depth; power of two, at least 2.

Ports:
- clk, input, 1, sole clock, rising edge.
- rst, input, 1, asynchronous, active-high reset.
- in_valid, input, 1, word present this cycle; no backpressure exists.
- in_data, input, 64, byte 0 of the word in [63:56], byte 7 in [7:0].
- in_byte_enable, input, 8, valid-byte mask; sampled only with in_eop.
- in_sop, input, 1, first word of packet.
- in_eop, input, 1, last word of packet; in_sop and in_eop may be set together.
- out_valid, output, 1, byte available.
- out_data, output, 8, current byte.
- out_sop, output, 1, first byte of packet.
- out_eop, output, 1, last byte of packet.
- out_ready, input, 1, consumer accepts the byte when out_valid and out_ready are both high.
- stat_valid, output, 1, one-cycle pulse: packet status is valid.
- stat_len, output, 16, packet length in bytes; saturates at 16'hFFFF.
- stat_err, output, 1, packet had a framing, mask or overflow error.
- overflow, output, 1, sticky: at least one word has been dropped; cleared only by rst.

## Operation

- Input FSM has two states, IDLE and IN_PKT.
  - IDLE, in_valid and in_sop: go to IN_PKT; if in_eop is also set, close the packet and stay in IDLE.
  - IDLE, in_valid without in_sop: drop the word; raise stat_valid with stat_err=1 and stat_len=0.
  - IN_PKT, in_valid and in_eop: close the packet and go to IDLE.
  - IN_PKT, in_valid and in_sop: report the open packet with stat_err=1; the new packet starts and the state stays IN_PKT. The byte stream shows out_sop with no preceding out_eop.
- Bytes per word:
  - A non-eop word carries 8 bytes; its in_byte_enable is ignored.
  - An eop word carries n leading ones, MSB-aligned. Legal masks are FF, FE, FC, F8, F0, E0, C0 and 80, giving n = 8 down to 1.
  - Any other mask (including 00) counts as 8 bytes and sets the packet error.
- Byte count: the per-packet accumulator counts every word accepted while framed, including words dropped to overflow, and saturates at 16'hFFFF.
- FIFO entry holds: data[63:0], cnt[3:0] (1..8), sop, eop.
  - Push happens on every framed in_valid when the FIFO is not full.
  - Full is evaluated before any same-cycle pop. A word arriving while full is dropped, sets overflow and sets the current packet's error.
  - A dropped eop word still closes the packet for status, but its out_eop never appears.
- Serialiser:
  - Byte index idx runs 0..cnt-1 over the head entry.
  - out_data = head.data[63-8*idx -: 8].
  - out_sop = head.sop and idx==0.
  - out_eop = head.eop and idx==cnt-1.
  - On accept, idx increments. At idx==cnt-1, the entry pops and idx returns to 0.
- out_valid = FIFO not empty.

## Timing

- Reset values: out_valid, out_data, out_sop, out_eop, stat_valid, stat_len, stat_err and overflow are all 0. FIFO is empty, idx=0, state is IDLE, accumulator is 0.
- Reset mid-packet discards FIFO contents and the partial status immediately.
- A word pushed at edge N is visible at out_valid after edge N, i.e. 1-cycle latency.
- stat_valid pulses in the cycle after the closing word's edge; stat_len and stat_err are held until the next pulse.
- The output sustains 1 byte per cycle. The input sustains 1 word per cycle only while the FIFO has room, so a continuous input stream overflows.
- Output signals are stable while out_valid=1 and out_ready=0.
- A simultaneous push and pop on a non-full FIFO keeps the occupancy unchanged.

## Test plan

- Ten bytes 0x00..0x09, with word 2 carrying in_byte_enable=C0 and eop; out_ready=1. Expect bytes 00..09 on consecutive cycles, out_sop on 00, out_eop on 09, then stat_len=10 and stat_err=0.
- Single-word packet (sop+eop, mask FF, data 0x1122334455667788). Expect 8 bytes 11..88 with out_sop on the first and out_eop on the last; stat_len=8.
- in_valid without sop while IDLE. Expect no output bytes, stat_valid with stat_err=1 and stat_len=0.
- sop, data word, then a second sop mid-packet. Expect stat_len=16 and stat_err=1 for the first packet; the second packet's first byte has out_sop.
- out_ready=0, FIFO_DEPTH+1 words of one packet. Expect overflow=1, the last word dropped, and stat_err=1 with stat_len=8*(FIFO_DEPTH+1).
- Illegal mask 0xA0 on the eop word of a 2-word packet. Expect 16 bytes output and stat_len=16 with stat_err=1. Asserting rst mid-drain clears out_valid immediately.
